// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Fetch sequencer. Owns the program counter, arbitrates
//                redirects against sequential PC+4 advance and decode
//                stalls, runs the valid/ready handshake to instruction
//                memory and delivers one registered instruction per
//                completed fetch. A one-entry skid register absorbs a
//                completion that arrives while decode is stalled.
//  Options     : PC_TRAP_EN - adds trap_i / mret_i / epc_i and the TRAP_VEC
//                parameter; trap and trap-return outrank jump and branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
`ifdef PC_TRAP_EN
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic [31:0] epc_i,
`endif
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_SKID  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] pend_q,     pend_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q,    if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] skid_pc_q,  skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic [31:0] drain_tgt;

  // Redirect arbitration: lower priorities first so higher ones override.
  always_comb begin
    redir     = 1'b0;
    redir_raw = 32'h0000_0000;
    if (br_taken_i) begin
      redir     = 1'b1;
      redir_raw = br_target_i;
    end
    if (jmp_i) begin
      redir     = 1'b1;
      redir_raw = jmp_target_i;
    end
`ifdef PC_TRAP_EN
    if (mret_i) begin
      redir     = 1'b1;
      redir_raw = epc_i;
    end
    if (trap_i) begin
      redir     = 1'b1;
      redir_raw = TRAP_VEC;
    end
`endif
    // Fetch addresses are always word aligned.
    redir_tgt = redir_raw & 32'hFFFF_FFFC;
  end

  assign pc_inc = pc_q + 32'd4;

  // Newest redirect replaces any target already waiting behind the drain.
  assign drain_tgt = redir ? redir_tgt : pend_q;

  // Next-state, request and delivery logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    // Decode consumes the held instruction whenever it is not stalled.
    if_valid_d   = if_valid_q & stall_i;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    imem_req_o   = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redir) begin
          pc_d = redir_tgt;
        end
      end

      S_FETCH: begin
        imem_req_o = 1'b1;
        if (redir) begin
          if_valid_d = 1'b0;
          if (imem_ready_i) begin
            pc_d = redir_tgt;
          end else begin
            // Request is in flight and must stay stable; park the target.
            pend_d  = redir_tgt;
            state_d = S_DRAIN;
          end
        end else if (imem_ready_i) begin
          pc_d = pc_inc;
          if (!if_valid_q || !stall_i) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata_i;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata_i;
            state_d      = S_SKID;
          end
        end
      end

      S_DRAIN: begin
        // Old request held until memory answers; its data is dropped.
        imem_req_o = 1'b1;
        if (redir) begin
          if_valid_d = 1'b0;
        end
        if (imem_ready_i) begin
          pc_d    = drain_tgt;
          state_d = S_FETCH;
        end else begin
          pend_d = drain_tgt;
        end
      end

      S_SKID: begin
        if (redir) begin
          // Skid contents are wrong-path; leaving SKID discards them.
          if_valid_d = 1'b0;
          pc_d       = redir_tgt;
          state_d    = S_FETCH;
        end else if (!stall_i) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_q       <= 32'h0000_0000;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0000_0000;
      if_instr_q   <= 32'h0000_0000;
      skid_pc_q    <= 32'h0000_0000;
      skid_instr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;

endmodule
`default_nettype wire
